board_grid_ctrl: RTL
====================

BOARD_GRID_CTRL -- requirements
Module: board_grid_ctrl

Interface
REQ-001 SHALL have parameter GRID_N, default 5, board edge length in cells (2..15).
REQ-002 SHALL have parameter MAX_LEN, default 3, longest ship in cells (1..GRID_N).
REQ-003 SHALL define derived widths CW = $clog2(GRID_N), NW = $clog2(GRID_N*GRID_N+1), LW = $clog2(MAX_LEN+1).
REQ-004 SHALL have port clk  in  1  rising-edge clock.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port clr  in  1  synchronous soft clear back to SETUP.
REQ-007 SHALL have port place_valid  in  1  placement request.
REQ-008 SHALL have ports place_board (in, 1: 0 player, 1 pc), place_row and place_col (in, CW each), place_len (in, LW) and place_vert (in, 1: 1 vertical/down, 0 horizontal/right).
REQ-009 SHALL have port place_done  out  1  one-cycle completion pulse.
REQ-010 SHALL have port place_err  out  1  valid with place_done; 1 means rejected.
REQ-011 SHALL have ports atk_valid (in, 1), atk_board (in, 1), atk_row and atk_col (in, CW each).
REQ-012 SHALL have ports atk_done (out, 1, one-cycle pulse) and atk_result (out, 2: 00 miss, 01 hit, 10 repeat, 11 invalid).
REQ-013 SHALL have ports start (in, 1: SETUP to PLAY request) and busy (out, 1: request not accepted this cycle).
REQ-014 SHALL have ports cells_left0 and cells_left1 (out, NW each), intact ship cells on each board.
REQ-015 SHALL have ports game_over (out, 1) and loser (out, 1), board index that reached zero.
REQ-016 SHALL have ports rd_board (in, 1), rd_row and rd_col (in, CW each), and rd_cell (out, 2), a combinational read port.

Function
REQ-017 SHALL encode cells as 00 water, 01 ship, 10 hit ship, 11 attacked water.
REQ-018 SHALL implement states IDLE_SETUP, PLACE_CHK, PLACE_WR, PLAY, ATK, OVER.
REQ-019 SHALL accept place_valid only in IDLE_SETUP; busy=0 only in IDLE_SETUP and PLAY.
REQ-020 SHALL register request fields on acceptance; inputs may change afterwards.
REQ-021 SHALL in PLACE_CHK flag an error when len==0, len>MAX_LEN, the start cell is out of range, the end cell exceeds GRID_N-1, or any target cell is not water.
REQ-022 SHALL in PLACE_WR write 01 to all len cells only when no error, add len to that board's counter, and pulse place_done (with place_err) that cycle, giving latency 2 cycles from acceptance.
REQ-023 SHALL leave the board and counters unchanged when a placement is rejected.
REQ-024 SHALL give place_valid priority over start in the same IDLE_SETUP cycle.
REQ-025 SHALL move IDLE_SETUP to PLAY on start only when both counters are nonzero; otherwise it stays in IDLE_SETUP with no pulse.
REQ-026 SHALL in PLAY accept atk_valid, go to ATK, and pulse atk_done the next cycle, giving latency 1.
REQ-027 SHALL on attack: ship becomes 10 with result 01 and the counter decrements; water becomes 11 with result 00; 10 or 11 give result 10 with no change; an out-of-range coordinate gives result 11 with no change.
REQ-028 SHALL pulse atk_done with result 11 one cycle after atk_valid in IDLE_SETUP, with no state change.
REQ-029 SHALL ignore place_valid in PLAY/OVER; place_done pulses with place_err=1 one cycle later.
REQ-030 SHALL, when a hit drives a counter to 0, set game_over=1 and loser=that board in the same cycle as atk_done, then enter OVER.
REQ-031 SHALL have OVER ignore all requests except clr; game_over is sticky.
REQ-032 SHALL have clr in any state set all cells to water, counters to 0, game_over/loser to 0, drop any in-flight request without a pulse, and go to IDLE_SETUP next cycle.
REQ-033 SHALL keep counters saturating: no wrap below 0 or above GRID_N*GRID_N.

Reset
REQ-034 SHALL on rst low immediately set state IDLE_SETUP, all cells 00, counters 0, and place_done, place_err, atk_done, atk_result, game_over, loser to 0.
REQ-035 SHALL abandon a request in progress at reset with no pulse after reset release.

Verification
REQ-036 SHALL cover: place board0 (1,1) len 3 horizontal -> place_done at T+2, err 0, cells (1,1..3)=01, cells_left0=3.
REQ-037 SHALL cover: place board0 (0,4) len 2 horizontal (GRID_N=5) -> err 1, board unchanged; then overlapping vertical (0,2) len 3 -> err 1.
REQ-038 SHALL cover: start with cells_left1=0 -> stays IDLE_SETUP; after placing board1 (4,0) len 1, start -> PLAY.
REQ-039 SHALL cover: attack board1 (4,0) -> atk_done T+1, result 01, cells_left1=0, game_over=1, loser=1; a further atk_valid -> no pulse.
REQ-040 SHALL cover: attack the same water cell twice -> results 00 then 10; attack row 7 -> result 11.
REQ-041 SHALL cover: rst low during PLACE_CHK -> no place_done, board all water; clr in OVER -> IDLE_SETUP, counters 0.

Source files
------------

// File: rtl/board_grid_ctrl.sv
// ---------------------------------------------------------------------------
// board_grid_ctrl
//
// Purpose:
//   Holds two square game boards (player = 0, pc = 1) of GRID_N x GRID_N
//   cells. During setup it places straight ships. During play it resolves
//   attacks. It tracks the number of intact ship cells on each board and
//   declares a loser when one board has no intact ship cells left.
//
// Cell encoding: 00 water, 01 ship, 10 hit ship, 11 attacked water.
//
// Ports:
//   clk, rst (async, active-low), clr (synchronous soft clear)
//   place_valid/board/row/col/len/vert -> placement request
//   place_done/place_err               -> one-cycle placement response
//   atk_valid/board/row/col            -> attack request
//   atk_done/atk_result                -> one-cycle attack response
//   start                              -> leave setup and enter play
//   busy                               -> high when requests are not accepted
//   cells_left0/1                      -> intact ship cells per board
//   game_over/loser                    -> sticky end-of-game flag and losing board
//   rd_board/row/col -> rd_cell        -> combinational board read port
// ---------------------------------------------------------------------------
module board_grid_ctrl #(
    parameter int GRID_N  = 5,
    parameter int MAX_LEN = 3,
    localparam int CW = $clog2(GRID_N),
    localparam int NW = $clog2(GRID_N * GRID_N + 1),
    localparam int LW = $clog2(MAX_LEN + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          place_valid,
    input  logic          place_board,
    input  logic [CW-1:0] place_row,
    input  logic [CW-1:0] place_col,
    input  logic [LW-1:0] place_len,
    input  logic          place_vert,
    output logic          place_done,
    output logic          place_err,
    input  logic          atk_valid,
    input  logic          atk_board,
    input  logic [CW-1:0] atk_row,
    input  logic [CW-1:0] atk_col,
    output logic          atk_done,
    output logic [1:0]    atk_result,
    input  logic          start,
    output logic          busy,
    output logic [NW-1:0] cells_left0,
    output logic [NW-1:0] cells_left1,
    output logic          game_over,
    output logic          loser,
    input  logic          rd_board,
    input  logic [CW-1:0] rd_row,
    input  logic [CW-1:0] rd_col,
    output logic [1:0]    rd_cell
);

    localparam int              CELLS   = GRID_N * GRID_N;
    localparam int              IW      = (CELLS > 1) ? $clog2(CELLS) : 1;
    localparam logic [7:0]      N8      = 8'(GRID_N);
    localparam logic [7:0]      MAXLEN8 = 8'(MAX_LEN);
    localparam logic [NW-1:0]   CAP     = NW'(CELLS);

    typedef enum logic [2:0] {
        IDLE_SETUP,
        PLACE_CHK,
        PLACE_WR,
        PLAY,
        ATK,
        OVER
    } state_t;

    state_t         r_state;
    state_t         w_stateNext;

    logic [1:0]     r_cells [0:1][0:CELLS-1];
    logic [NW-1:0]  r_cnt [0:1];

    logic           r_board;
    logic [CW-1:0]  r_row;
    logic [CW-1:0]  r_col;
    logic [LW-1:0]  r_len;
    logic           r_vert;
    logic           r_err;
    logic [1:0]     r_atkRes;
    logic           r_rejPend;
    logic           r_atkInvPend;
    logic           r_gameOver;
    logic           r_loser;

    logic [7:0]     w_row8;
    logic [7:0]     w_col8;
    logic [7:0]     w_len8;
    logic [7:0]     w_endRow;
    logic [7:0]     w_endCol;
    logic [7:0]     w_chkRow;
    logic [7:0]     w_chkCol;
    logic           w_placeErr;
    logic [NW:0]    w_sum;
    logic [NW-1:0]  w_cntAdd;

    logic           w_atkInRange;
    logic [IW-1:0]  w_atkIdx;
    logic [1:0]     w_atkCell;
    logic [1:0]     w_atkRes;

    // Flattened row-major cell index. Callers check the range first.
    function automatic logic [IW-1:0] cellIdx(input logic [7:0] row, input logic [7:0] col);
        return IW'(16'(row) * 16'(N8) + 16'(col));
    endfunction

    // Check the latched placement. The cell scan only looks at cells that
    // are on the board, because all range errors are caught first.
    always_comb begin
        w_row8     = 8'(r_row);
        w_col8     = 8'(r_col);
        w_len8     = 8'(r_len);
        w_endRow   = r_vert ? (w_row8 + w_len8 - 8'd1) : w_row8;
        w_endCol   = r_vert ? w_col8 : (w_col8 + w_len8 - 8'd1);
        w_chkRow   = w_row8;
        w_chkCol   = w_col8;
        w_placeErr = 1'b0;
        if ((w_len8 == 8'd0) || (w_len8 > MAXLEN8) || (w_row8 >= N8) || (w_col8 >= N8) ||
            (w_endRow >= N8) || (w_endCol >= N8)) begin
            w_placeErr = 1'b1;
        end else begin
            for (int k = 0; k < MAX_LEN; k++) begin
                w_chkRow = r_vert ? (w_row8 + 8'(k)) : w_row8;
                w_chkCol = r_vert ? w_col8 : (w_col8 + 8'(k));
                if ((8'(k) < w_len8) && (r_cells[r_board][cellIdx(w_chkRow, w_chkCol)] != 2'b00)) begin
                    w_placeErr = 1'b1;
                end
            end
        end
    end

    // Saturating add of a new ship length to its board counter.
    always_comb begin
        w_sum    = {1'b0, r_cnt[r_board]} + (NW+1)'(r_len);
        w_cntAdd = (w_sum > {1'b0, CAP}) ? CAP : w_sum[NW-1:0];
    end

    // Resolve the attack when it is accepted. The cell and counter update at
    // that edge, so the response cycle already shows the new counter and
    // the game_over flag together with atk_done.
    always_comb begin
        w_atkInRange = (8'(atk_row) < N8) && (8'(atk_col) < N8);
        w_atkIdx     = cellIdx(8'(atk_row), 8'(atk_col));
        w_atkCell    = w_atkInRange ? r_cells[atk_board][w_atkIdx] : 2'b00;
        w_atkRes     = 2'b11;
        if (w_atkInRange) begin
            case (w_atkCell)
                2'b00:   w_atkRes = 2'b00;
                2'b01:   w_atkRes = 2'b01;
                default: w_atkRes = 2'b10;
            endcase
        end
    end

    // Combinational read port. Out-of-range coordinates read as water.
    always_comb begin
        rd_cell = 2'b00;
        if ((8'(rd_row) < N8) && (8'(rd_col) < N8)) begin
            rd_cell = r_cells[rd_board][cellIdx(8'(rd_row), 8'(rd_col))];
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE_SETUP;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state logic and response pulses. While clr is high, all pulses
    // are suppressed, so a request that is still in progress ends silently.
    always_comb begin
        w_stateNext = r_state;
        busy        = 1'b1;
        place_done  = 1'b0;
        place_err   = 1'b0;
        atk_done    = 1'b0;
        atk_result  = 2'b00;
        case (r_state)
            IDLE_SETUP: begin
                busy = 1'b0;
                if (place_valid) begin
                    w_stateNext = PLACE_CHK;
                end else if (start && (r_cnt[0] != '0) && (r_cnt[1] != '0)) begin
                    w_stateNext = PLAY;
                end
            end
            PLACE_CHK: w_stateNext = PLACE_WR;
            PLACE_WR:  w_stateNext = IDLE_SETUP;
            PLAY: begin
                busy = 1'b0;
                if (atk_valid) begin
                    w_stateNext = ATK;
                end
            end
            ATK:       w_stateNext = r_gameOver ? OVER : PLAY;
            OVER:      w_stateNext = OVER;
            default:   w_stateNext = IDLE_SETUP;
        endcase
        if (clr) begin
            w_stateNext = IDLE_SETUP;
        end else begin
            if (r_state == PLACE_WR) begin
                place_done = 1'b1;
                place_err  = r_err;
            end else if (r_rejPend) begin
                place_done = 1'b1;
                place_err  = 1'b1;
            end
            if (r_state == ATK) begin
                atk_done   = 1'b1;
                atk_result = r_atkRes;
            end else if (r_atkInvPend) begin
                atk_done   = 1'b1;
                atk_result = 2'b11;
            end
        end
    end

    // Board contents, counters, latched requests and pending one-cycle
    // responses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < CELLS; i++) begin
                    r_cells[b][i] <= 2'b00;
                end
                r_cnt[b] <= '0;
            end
            r_board      <= 1'b0;
            r_row        <= '0;
            r_col        <= '0;
            r_len        <= '0;
            r_vert       <= 1'b0;
            r_err        <= 1'b0;
            r_atkRes     <= 2'b00;
            r_rejPend    <= 1'b0;
            r_atkInvPend <= 1'b0;
            r_gameOver   <= 1'b0;
            r_loser      <= 1'b0;
        end else if (clr) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < CELLS; i++) begin
                    r_cells[b][i] <= 2'b00;
                end
                r_cnt[b] <= '0;
            end
            r_err        <= 1'b0;
            r_rejPend    <= 1'b0;
            r_atkInvPend <= 1'b0;
            r_gameOver   <= 1'b0;
            r_loser      <= 1'b0;
        end else begin
            r_rejPend    <= 1'b0;
            r_atkInvPend <= 1'b0;
            case (r_state)
                IDLE_SETUP: begin
                    if (place_valid) begin
                        r_board <= place_board;
                        r_row   <= place_row;
                        r_col   <= place_col;
                        r_len   <= place_len;
                        r_vert  <= place_vert;
                    end
                    if (atk_valid) begin
                        r_atkInvPend <= 1'b1;
                    end
                end
                PLACE_CHK: r_err <= w_placeErr;
                PLACE_WR: begin
                    if (!r_err) begin
                        for (int k = 0; k < MAX_LEN; k++) begin
                            if (8'(k) < w_len8) begin
                                r_cells[r_board][cellIdx(r_vert ? (w_row8 + 8'(k)) : w_row8,
                                                         r_vert ? w_col8 : (w_col8 + 8'(k)))] <= 2'b01;
                            end
                        end
                        r_cnt[r_board] <= w_cntAdd;
                    end
                end
                PLAY: begin
                    if (place_valid) begin
                        r_rejPend <= 1'b1;
                    end
                    if (atk_valid) begin
                        r_atkRes <= w_atkRes;
                        if (w_atkRes == 2'b01) begin
                            r_cells[atk_board][w_atkIdx] <= 2'b10;
                            if (r_cnt[atk_board] != '0) begin
                                r_cnt[atk_board] <= r_cnt[atk_board] - NW'(1);
                            end
                            if (r_cnt[atk_board] == NW'(1)) begin
                                r_gameOver <= 1'b1;
                                r_loser    <= atk_board;
                            end
                        end else if (w_atkRes == 2'b00) begin
                            r_cells[atk_board][w_atkIdx] <= 2'b11;
                        end
                    end
                end
                OVER: begin
                    if (place_valid) begin
                        r_rejPend <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cells_left0 = r_cnt[0];
    assign cells_left1 = r_cnt[1];
    assign game_over   = r_gameOver;
    assign loser       = r_loser;

endmodule
